// File: rtl/act_unit_pipe_pkg.sv
// Shared definitions for the piecewise-linear activation pipeline:
// default geometry, mode encodings and the |x| region codes.
package act_unit_pipe_pkg;

  localparam int ACT_WIDTH = 24;
  localparam int ACT_FRAC  = 16;
  localparam int ACT_LANES = 4;

  localparam logic ACT_MODE_TANH = 1'b0;
  localparam logic ACT_MODE_SIGM = 1'b1;

  // R0: |x| < 0.5, R1: [0.5,1), R2: [1,2), R3: >= 2
  typedef enum logic [1:0] {
    REG_R0 = 2'd0,
    REG_R1 = 2'd1,
    REG_R2 = 2'd2,
    REG_R3 = 2'd3
  } region_e;

endpackage

// File: rtl/act_unit_pipe_pla.sv
// Combinational piecewise-linear tanh for one lane; region and sign are
// precomputed upstream so this is just a shift, an add and a mux.
module pla_tanh_lane
  import act_unit_pipe_pkg::*;
#(
  parameter int WIDTH = ACT_WIDTH,
  parameter int FRAC  = ACT_FRAC
) (
  input  logic signed [WIDTH-1:0] x,
  input  region_e                 region,
  input  logic                    sign,
  output logic signed [WIDTH-1:0] t
);

  localparam logic signed [WIDTH-1:0] ONE     = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [WIDTH-1:0] HALF    = ONE >>> 1;
  localparam logic signed [WIDTH-1:0] QUARTER = ONE >>> 2;

  always_comb begin
    t = x;
    unique case (region)
      REG_R0: t = x;
      REG_R1: t = (x >>> 1) + (sign ? -QUARTER : QUARTER);
      REG_R2: t = (x >>> 2) + (sign ? -HALF : HALF);
      REG_R3: t = sign ? -ONE : ONE;
    endcase
  end

endmodule

// File: rtl/act_unit_pipe.sv
// Three-stage multi-lane tanh/sigmoid unit with derivative output.
// S1 prescale + region classify, S2 PLA, S3 derivative multiply.
module act_unit_pipe
  import act_unit_pipe_pkg::*;
#(
  parameter int WIDTH = ACT_WIDTH,
  parameter int FRAC  = ACT_FRAC,
  parameter int LANES = ACT_LANES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_mode,
  input  logic [LANES*WIDTH-1:0] i_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*WIDTH-1:0] o_act,
  output logic [LANES*WIDTH-1:0] o_dact
);

  localparam logic signed [WIDTH-1:0] ONE      = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [WIDTH-1:0] HALF     = ONE >>> 1;
  localparam logic signed [WIDTH-1:0] TWO      = ONE <<< 1;
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: a beat moves on a rising edge when valid and ready are both
  // high; one global enable stalls every stage together while o_valid is
  // held without i_ready, so outputs stay stable during backpressure.
  logic en, s1_load, s2_load, s3_load;
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic s1_mode_q, s2_mode_q;

  logic signed [WIDTH-1:0] x_in     [LANES];
  logic signed [WIDTH-1:0] s1_x_d   [LANES];
  logic        [WIDTH-1:0] abs_x    [LANES];
  logic                    s1_sign_d[LANES];
  region_e                 s1_reg_d [LANES];
  logic signed [WIDTH-1:0] s1_x_q   [LANES];
  logic                    s1_sign_q[LANES];
  region_e                 s1_reg_q [LANES];

  logic signed [WIDTH-1:0]   t_w    [LANES];
  logic signed [WIDTH-1:0]   s2_y_d [LANES];
  logic signed [WIDTH-1:0]   s2_y_q [LANES];
  logic signed [WIDTH-1:0]   mul_b  [LANES];
  logic signed [2*WIDTH-1:0] prod   [LANES];
  logic signed [WIDTH-1:0]   s3_dy_d[LANES];
  logic signed [WIDTH-1:0]   s3_y_q [LANES];
  logic signed [WIDTH-1:0]   s3_dy_q[LANES];

  assign en      = ~s3_valid_q | i_ready;
  assign o_ready = en;
  assign o_valid = s3_valid_q;
  assign s1_load = en & i_valid;
  assign s2_load = en & s1_valid_q;
  assign s3_load = en & s2_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else if (en) begin
      s1_valid_q <= i_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
    end
  end

  // Sigmoid reuses the tanh PLA: sigm(x) = 0.5 + 0.5*tanh(x/2), so the
  // region is classified on the prescaled value.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      x_in[k]      = i_data[k*WIDTH +: WIDTH];
      s1_x_d[k]    = (i_mode == ACT_MODE_TANH) ? x_in[k] : (x_in[k] >>> 1);
      s1_sign_d[k] = s1_x_d[k][WIDTH-1];
      abs_x[k]     = s1_sign_d[k] ? -s1_x_d[k] : s1_x_d[k];
      if (s1_x_d[k] == MOST_NEG || abs_x[k] >= $unsigned(TWO)) s1_reg_d[k] = REG_R3;
      else if (abs_x[k] >= $unsigned(ONE))                      s1_reg_d[k] = REG_R2;
      else if (abs_x[k] >= $unsigned(HALF))                     s1_reg_d[k] = REG_R1;
      else                                                      s1_reg_d[k] = REG_R0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mode_q <= ACT_MODE_TANH;
      for (int k = 0; k < LANES; k++) begin
        s1_x_q[k]    <= '0;
        s1_sign_q[k] <= 1'b0;
        s1_reg_q[k]  <= REG_R0;
      end
    end else if (s1_load) begin
      s1_mode_q <= i_mode;
      for (int k = 0; k < LANES; k++) begin
        s1_x_q[k]    <= s1_x_d[k];
        s1_sign_q[k] <= s1_sign_d[k];
        s1_reg_q[k]  <= s1_reg_d[k];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_pla
    pla_tanh_lane #(.WIDTH(WIDTH), .FRAC(FRAC)) u_pla (
      .x      (s1_x_q[g]),
      .region (s1_reg_q[g]),
      .sign   (s1_sign_q[g]),
      .t      (t_w[g])
    );
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      s2_y_d[k] = (s1_mode_q == ACT_MODE_SIGM) ? ((t_w[k] >>> 1) + HALF) : t_w[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_mode_q <= ACT_MODE_TANH;
      for (int k = 0; k < LANES; k++) s2_y_q[k] <= '0;
    end else if (s2_load) begin
      s2_mode_q <= s1_mode_q;
      for (int k = 0; k < LANES; k++) s2_y_q[k] <= s2_y_d[k];
    end
  end

  // Both derivatives share one multiplier per lane: y*y for tanh,
  // y*(ONE-y) for sigmoid.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      mul_b[k]   = (s2_mode_q == ACT_MODE_SIGM) ? (ONE - s2_y_q[k]) : s2_y_q[k];
      prod[k]    = s2_y_q[k] * mul_b[k];
      s3_dy_d[k] = (s2_mode_q == ACT_MODE_SIGM) ? WIDTH'(prod[k] >>> FRAC)
                                                : ONE - WIDTH'(prod[k] >>> FRAC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        s3_y_q[k]  <= '0;
        s3_dy_q[k] <= '0;
      end
    end else if (s3_load) begin
      for (int k = 0; k < LANES; k++) begin
        s3_y_q[k]  <= s2_y_q[k];
        s3_dy_q[k] <= s3_dy_d[k];
      end
    end
  end

  always_comb begin
    o_act  = '0;
    o_dact = '0;
    for (int k = 0; k < LANES; k++) begin
      o_act[k*WIDTH +: WIDTH]  = s3_y_q[k];
      o_dact[k*WIDTH +: WIDTH] = s3_dy_q[k];
    end
  end

endmodule
